// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract unit: one CW-bit chunk is resolved per stage,
// with the carry rippling stage to stage behind a single global valid/ready advance enable.
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  // Per-stage registers; index k holds the state of pipeline stage k+1.
  logic             v_q   [STAGES];
  logic [WIDTH-1:0] acc_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic             c_q   [STAGES];

  // Stage inputs: entry 0 is the incoming beat, entry k is the register of stage k.
  logic             src_v   [STAGES];
  logic [WIDTH-1:0] src_acc [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic             src_c   [STAGES];

  logic [WIDTH-1:0] nxt_acc [STAGES];
  logic             nxt_c   [STAGES];
  logic [CW:0]      chunk;
  logic             en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    src_v   = v_q;
    src_acc = acc_q;
    src_a   = a_q;
    src_b   = b_q;
    src_c   = c_q;
    src_v[0]   = in_valid;
    src_acc[0] = '0;
    src_a[0]   = in1;
    src_b[0]   = sub ? ~in2 : in2;
    src_c[0]   = sub ? ~cin : cin;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_v[k]   = v_q[k-1];
      src_acc[k] = acc_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_c[k]   = c_q[k-1];
    end
  end

  // Stage k+1 resolves chunk k only; lower chunks pass through already settled.
  always_comb begin
    nxt_acc = src_acc;
    nxt_c   = src_c;
    chunk   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      chunk = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
            + {{CW{1'b0}}, src_c[k]};
      nxt_acc[k][k*CW +: CW] = chunk[CW-1:0];
      nxt_c[k]               = chunk[CW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '{default: '0};
      acc_q <= '{default: '0};
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      c_q   <= '{default: '0};
    end else if (en) begin
      v_q   <= src_v;
      acc_q <= nxt_acc;
      a_q   <= src_a;
      b_q   <= src_b;
      c_q   <= nxt_c;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                  && (acc_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed corner cases, backpressure, mid-stream reset and a
// parameter sweep, all scored against an arithmetic reference model.
module tb_adder_pipe;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic [31:0] acc;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Signed/unsigned arithmetic reference: result of a+b+ci or a-b-ci at width w.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic sb);
    exp_t    r;
    longint  ua, ub, sa, sbv, c1, full, st, lim;
    logic [63:0] m;
    r   = '0;
    m   = (64'd1 << w) - 64'd1;
    lim = longint'(64'd1 << (w - 1));
    ua  = longint'(a);
    ub  = longint'(b);
    c1  = ci ? 64'sd1 : 64'sd0;
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sbv = (ub >= lim) ? ub - 2 * lim : ub;
    if (!sb) begin
      full   = ua + ub + c1;
      st     = sa + sbv + c1;
      r.cout = (full >= 2 * lim);
    end else begin
      full   = ua - ub - c1;
      st     = sa - sbv - c1;
      r.cout = (ua >= ub + c1);
    end
    r.sum = 64'(full) & m;
    r.ovf = (st >= lim) || (st < -lim);
    return r;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance (16/4) ----------------
  logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] in1, in2, sum;

  adder_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  exp_t        exp_q[$];
  exp_t        e;
  int          n_push = 0;
  int          n_pop  = 0;
  logic        stalled = 1'b0;
  logic [15:0] st_sum;
  logic        st_cout, st_ovf;
  logic        rand_rdy = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      n_push -= exp_q.size();
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (stalled) begin
        chk("stall_sum", 64'(sum), 64'(st_sum));
        chk("stall_flags", 64'({out_valid, cout, ovf}), 64'({1'b1, st_cout, st_ovf}));
      end
      if (out_valid && out_ready) begin
        n_pop++;
        chk("result_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sum", 64'(sum), e.sum);
          chk("cout", 64'(cout), 64'(e.cout));
          chk("ovf", 64'(ovf), 64'(e.ovf));
        end
      end
      stalled = out_valid && !out_ready;
      st_sum  = sum;
      st_cout = cout;
      st_ovf  = ovf;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(16, 64'(in1), 64'(in2), cin, sub));
        n_push++;
      end
    end
  end

  task automatic beat1(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb,
                       input logic [15:0] es, input logic ec, input logic eo);
    @(posedge clk) #1;
    in_valid = 1'b1; in1 = a; in2 = b; cin = ci; sub = sb;
    @(posedge clk) #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early"}, 64'(out_valid), 64'(0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  task automatic send_beats(input int n, input bit gaps);
    int  sent  = 0;
    int  guard = 0;
    logic took;
    @(posedge clk) #1;
    while (sent < n && guard < 2000) begin
      guard++;
      if (!in_valid && (!gaps || $urandom_range(3) != 0)) begin
        in_valid = 1'b1;
        in1 = 16'($urandom);
        in2 = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
      end
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk) #1;
      if (took) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("send_beats_done", 64'(sent), 64'(n));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- parameter sweep instances ----------------
  localparam int SW_W[3] = '{8, 8, 32};
  localparam int SW_S[3] = '{1, 2, 8};
  int sweep_done = 0;

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = SW_W[g];
    localparam int S = SW_S[g];
    logic          s_rst_n, s_iv, s_ir, s_ov, s_ci, s_sb, s_co, s_of;
    logic [W-1:0]  s_a, s_b, s_sm;
    exp_t          q[$];
    exp_t          se;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut_s (
      .clk(clk), .rst_n(s_rst_n), .in_valid(s_iv), .in_ready(s_ir),
      .in1(s_a), .in2(s_b), .cin(s_ci), .sub(s_sb),
      .out_valid(s_ov), .out_ready(1'b1),
      .sum(s_sm), .cout(s_co), .ovf(s_of)
    );

    always @(negedge clk) begin
      if (s_rst_n) begin
        if (s_ov) begin
          chk($sformatf("sw%0d_expected", g), 64'(q.size() != 0), 64'(1));
          if (q.size() != 0) begin
            se = q.pop_front();
            chk($sformatf("sw%0d_sum", g), 64'(s_sm), se.sum);
            chk($sformatf("sw%0d_flags", g), 64'({s_co, s_of}), 64'({se.cout, se.ovf}));
            chk($sformatf("sw%0d_latency", g), 64'(cyc - se.acc), 64'(S - 1));
          end
        end
        if (s_iv && s_ir) begin
          se     = model(W, 64'(s_a), 64'(s_b), s_ci, s_sb);
          se.acc = cyc + 1;
          q.push_back(se);
        end
      end
    end

    initial begin
      s_rst_n = 1'b0; s_iv = 1'b0; s_a = '0; s_b = '0; s_ci = 1'b0; s_sb = 1'b0;
      repeat (2) @(posedge clk);
      #1 s_rst_n = 1'b1;
      for (int n = 0; n < 60; n++) begin
        s_iv = ($urandom_range(4) != 0);
        s_a  = W'({$urandom, $urandom});
        s_b  = W'({$urandom, $urandom});
        s_ci = 1'($urandom);
        s_sb = 1'($urandom);
        @(posedge clk) #1;
      end
      s_iv = 1'b0;
      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk($sformatf("sw%0d_drain", g), 64'(q.size()), 64'(0));
      sweep_done++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(sum), 64'(16'h0000));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk) #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_out_valid", 64'(out_valid), 64'(0));
    end

    beat1("ripple_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    beat1("ripple_aaaa", 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    beat1("ovf_add",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    beat1("sub_neg",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    beat1("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: continuous 8-beat stream with a 3-cycle consumer stall mid-stream.
    fork
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send_beats(8, 1'b0);
    drain();

    // Reset with three beats in flight; none of them may ever emerge.
    send_beats(3, 1'b0);
    rst_n = 1'b0;
    @(posedge clk) #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
    end
    beat1("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    // Random traffic under random consumer readiness.
    rand_rdy = 1'b1;
    fork
      begin
        while (rand_rdy) begin
          @(posedge clk);
          #1 out_ready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
        end
        out_ready = 1'b1;
      end
    join_none
    send_beats(120, 1'b1);
    rand_rdy = 1'b0;
    drain();
    chk("beat_count", 64'(n_pop), 64'(n_push));

    for (int i = 0; i < 5000 && sweep_done < 3; i++) @(posedge clk);
    chk("sweep_finished", 64'(sweep_done), 64'(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined add/subtract unit: the multi-cycle successor to the single-cycle 8-bit adder. Splits a WIDTH-bit operation into STAGES equal chunks, resolving one chunk per clock with the carry rippling stage to stage. It sits between a valid/ready producer and consumer in the datapath, providing one result per cycle at full throughput, backpressure, a subtract mode and signed-overflow detection.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of chunks; chunk width is CW = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: A+B+cin; 1: A−B−cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- Effective operand B' = sub ? ~in2 : in2; effective carry c0 = sub ? ~cin : cin. Result = in1 + B' + c0, WIDTH+1 bits; sum = low WIDTH bits, cout = bit WIDTH.
- ovf = (in1[MSB] == B'[MSB]) && (sum[MSB] != in1[MSB]).
- Stage k (1..STAGES) register holds: valid bit, sum chunks 0..k−1 resolved, remaining upper chunks of in1 and B', carry into chunk k, and in1/B' MSBs for ovf. Stage k adds chunk k−1 (CW bits plus carry) only.
- Global advance enable en = !out_valid || out_ready. When en=1 every stage loads from its predecessor (stage 1 loads the input beat, with valid = in_valid). When en=0 all stages hold.
- in_ready = en (combinational from out_valid and out_ready).
- Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
- Bubbles (stages with valid=0) advance with the pipe; they are not collapsed during stall.
- Ordering strictly FIFO; no beat dropped or duplicated under any out_ready pattern.
- sum/cout/ovf are the final-stage registers; their value is only meaningful while out_valid=1.

## Timing
- Reset (rst_n=0 at rising edge): all stage valid bits, out_valid, sum, cout, ovf and all internal data cleared to 0. in_ready reads 1 after reset (out_valid=0).
- Reset mid-operation: all in-flight beats discarded on that edge; no result for them ever appears. Inputs during reset are ignored.
- Latency: beat accepted at edge t appears with out_valid=1 after edge t+STAGES−1 (i.e. STAGES register stages, visible in cycle following the STAGES-th edge counting the acceptance edge). With out_ready held 1, throughput is one beat per cycle.
- Stall: out_valid=1 and out_ready=0 → in_ready=0 that cycle, all registers hold, outputs stable until accepted.
- Simultaneous output accept and input accept in the same cycle is legal and required for full throughput.
- STAGES=1 degenerates to a single registered adder with the same handshake.
- Wrap-around: sum is modulo 2^WIDTH; carry out only on cout.

## Test plan
- Reset: hold rst_n=0 two cycles → out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1; release, then check 4 cycles with in_valid=0 keep out_valid=0.
- Carry ripple across all chunks: 0xFFFF+0x0001, cin=0, sub=0 → after 4 edges sum=0x0000, cout=1, ovf=0; 0xAAAA+0x5555, cin=1 → sum=0x0000, cout=1, ovf=0.
- Signed overflow and subtract: 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1; sub=1, 0x0005−0x0007, cin=0 → sum=0xFFFE, cout=0, ovf=0; sub=1, 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Back-to-back with backpressure: issue 8 random beats continuously, drop out_ready for 3 cycles mid-stream → in_ready=0 exactly while out_valid&&!out_ready, outputs stable while stalled, all 8 results match a reference model in order, none lost or duplicated.
- Reset mid-operation: 3 beats in flight, pulse rst_n=0 one cycle → out_valid=0 next cycle and stays 0; a beat issued after release returns correct result after 4 edges.
- Parameter sweep: rerun random add/sub with WIDTH=8/STAGES=1, WIDTH=8/STAGES=2, WIDTH=32/STAGES=8 → all results match model, latency equals STAGES.
